seq_player: RTL

SEQ_PLAYER -- requirements
Module: seq_player

---
 rtl/seq_player.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/seq_player.sv
// Colour-sequence player: plays nivel+1 colours from an external ROM, then checks the player's
// presses. Optional build macro SEQ_TIMEOUT_EN adds an ESPERA response timeout (TEMPO_LIMITE).
module seq_player #(
  parameter int unsigned TEMPO_LED    = 25000000,
  parameter int unsigned TEMPO_PAUSA  = 12500000,
  parameter int unsigned TEMPO_LIMITE = 250000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic [3:0] nivel,
  input  logic [3:0] botoes,
  input  logic [3:0] saida_rom,
  output logic [3:0] address,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       aguardando,
  output logic       acerto,
  output logic       erro
);

  if (TEMPO_LED < 1 || TEMPO_LED > 32'h03ff_ffff) begin : g_bad_tempo_led
    $fatal(1, "TEMPO_LED out of range");
  end
  if (TEMPO_PAUSA < 1 || TEMPO_PAUSA > 32'h03ff_ffff) begin : g_bad_tempo_pausa
    $fatal(1, "TEMPO_PAUSA out of range");
  end
  if (TEMPO_LIMITE < 1) begin : g_bad_tempo_limite
    $fatal(1, "TEMPO_LIMITE out of range");
  end

  localparam logic [25:0] LedLast   = 26'(TEMPO_LED - 1);
  localparam logic [25:0] PausaLast = 26'(TEMPO_PAUSA - 1);

  typedef enum logic [2:0] {
    StIdle,
    StMostra,
    StPausa,
    StEspera,
    StAcerto,
    StErro
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  nivel_q, nivel_d;
  logic [25:0] timer_q, timer_d;
  logic        acerto_q, erro_q;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned LimW = $clog2(TEMPO_LIMITE + 1);
  localparam logic [LimW-1:0] LimLast = LimW'(TEMPO_LIMITE - 1);

  logic [LimW-1:0] lim_q, lim_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lim_q <= '0;
    end else begin
      lim_q <= lim_d;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      nivel_q  <= '0;
      timer_q  <= '0;
      acerto_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      nivel_q  <= nivel_d;
      timer_q  <= timer_d;
      acerto_q <= (state_d == StAcerto);
      erro_q   <= (state_d == StErro);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nivel_d = nivel_q;
    timer_d = timer_q;
`ifdef SEQ_TIMEOUT_EN
    lim_d   = lim_q;
`endif
    unique case (state_q)
      StIdle: begin
        idx_d   = '0;
        timer_d = '0;
        if (iniciar) begin
          nivel_d = nivel;
          state_d = StMostra;
        end
      end
      StMostra: begin
        if (timer_q == LedLast) begin
          timer_d = '0;
          state_d = StPausa;
        end else begin
          timer_d = timer_q + 26'd1;
        end
      end
      StPausa: begin
        if (timer_q == PausaLast) begin
          timer_d = '0;
          if (idx_q == nivel_q) begin
            idx_d   = '0;
            state_d = StEspera;
`ifdef SEQ_TIMEOUT_EN
            lim_d   = '0;
`endif
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = StMostra;
          end
        end else begin
          timer_d = timer_q + 26'd1;
        end
      end
      StEspera: begin
        if (botoes == 4'b0000) begin
`ifdef SEQ_TIMEOUT_EN
          if (lim_q == LimLast) begin
            state_d = StErro;
          end else begin
            lim_d = lim_q + 1'b1;
          end
`endif
        end else if (botoes == saida_rom) begin
`ifdef SEQ_TIMEOUT_EN
          lim_d = '0;
`endif
          // Last step matched: the whole sequence was reproduced.
          if (idx_q == nivel_q) begin
            state_d = StAcerto;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          state_d = StErro;
        end
      end
      StAcerto, StErro: begin
        idx_d   = '0;
        timer_d = '0;
        state_d = StIdle;
      end
      default: begin
        idx_d   = '0;
        timer_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    address    = idx_q;
    leds       = (state_q == StMostra) ? saida_rom : 4'b0000;
    ocupado    = (state_q != StIdle);
    aguardando = (state_q == StEspera);
    acerto     = acerto_q;
    erro       = erro_q;
  end

endmodule
